// File: rtl/cache_drain_unit_pkg.sv
// rtl/cache_drain_unit_pkg.sv - shared cache drain constants and FSM state type
//
// Purpose : the drain opcode, default line width and the drain FSM state
//           encoding that the cache drain logic and its neighbours agree on.
// Ports   : none (package).
package cache_drain_unit_pkg;

    // MEM-stage opcode that raises drain_req for one cycle.
    localparam logic [6:0] DRAIN_OPC = 7'h7F;

    // Default width of one cache / memory line.
    localparam int LINE_BITS_DEFAULT = 128;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CHK  = 3'd2,
        WR   = 3'd3,
        CLR  = 3'd4,
        DONE = 3'd5
    } drain_state_t;

    // Decode helper for the MEM stage that produces drain_req.
    function automatic logic is_drain_opcode(input logic [6:0] opc);
        return opc == DRAIN_OPC;
    endfunction

endpackage

// File: rtl/cache_drain_unit.sv
// rtl/cache_drain_unit.sv - walks a direct-mapped cache and writes back dirty lines
//
// Purpose : on a one-cycle drain_req the unit visits every cache line once in
//           ascending order, writes each valid+dirty line to memory, and pulses
//           arr_clr so the array drops the dirty bit (and valid when the array
//           is built with INVALIDATE=1). The pipeline is stalled while busy.
// Ports   :
//   clock, reset           rising-edge clock, synchronous active-high reset
//   drain_req              one-cycle drain request from the MEM stage
//   busy                   drain in progress (pipeline stall)
//   drain_done             one-cycle pulse when the drain finishes
//   arr_idx                cache array read/update index
//   arr_valid, arr_dirty   line state, registered one cycle after arr_idx
//   arr_tag, arr_data      line tag and data, same timing as arr_valid
//   arr_clr                clear dirty (and valid) of line arr_idx this cycle
//   mem_req, mem_addr,     line write request towards memory, held until
//   mem_wdata, mem_ready     accepted in a cycle with mem_req && mem_ready
//   lines_written          number of lines written back by the last drain
module cache_drain_unit
    import cache_drain_unit_pkg::*;
#(
    parameter int NUM_LINES  = 4,
    parameter int LINE_BITS  = LINE_BITS_DEFAULT,
    parameter int TAG_BITS   = 26,
    parameter int INVALIDATE = 0,
    localparam int IDX_BITS   = $clog2(NUM_LINES),
    localparam int LADDR_BITS = TAG_BITS + IDX_BITS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  drain_req,
    output logic                  busy,
    output logic                  drain_done,
    output logic [IDX_BITS-1:0]   arr_idx,
    input  logic                  arr_valid,
    input  logic                  arr_dirty,
    input  logic [TAG_BITS-1:0]   arr_tag,
    input  logic [LINE_BITS-1:0]  arr_data,
    output logic                  arr_clr,
    output logic                  mem_req,
    output logic [LADDR_BITS-1:0] mem_addr,
    output logic [LINE_BITS-1:0]  mem_wdata,
    input  logic                  mem_ready,
    output logic [IDX_BITS:0]     lines_written
);

    // The array itself applies the INVALIDATE behaviour on arr_clr; this
    // unit only checks that the build parameters make sense.
    generate
        if (NUM_LINES < 2 || (NUM_LINES & (NUM_LINES - 1)) != 0) begin : g_bad_lines
            $error("cache_drain_unit: NUM_LINES must be a power of two >= 2");
        end
        if (INVALIDATE != 0 && INVALIDATE != 1) begin : g_bad_inval
            $error("cache_drain_unit: INVALIDATE must be 0 or 1");
        end
    endgenerate

    drain_state_t        state;
    logic [IDX_BITS-1:0] idx;
    logic                last_line;

    // The index stops at the last line instead of wrapping, so the final
    // visit leads to DONE and never back to line 0.
    assign last_line = (idx == IDX_BITS'(NUM_LINES - 1));
    assign arr_idx   = idx;

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            idx           <= '0;
            busy          <= 1'b0;
            drain_done    <= 1'b0;
            mem_req       <= 1'b0;
            arr_clr       <= 1'b0;
            lines_written <= '0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Requests arriving in any other state are dropped.
                    if (drain_req) begin
                        state         <= RD;
                        idx           <= '0;
                        lines_written <= '0;
                        busy          <= 1'b1;
                    end
                end

                RD: begin
                    // arr_idx is presented now; line state arrives next cycle.
                    state <= CHK;
                end

                CHK: begin
                    if (arr_valid && arr_dirty) begin
                        // Latch the line into the request registers so the
                        // request stays stable however long memory stalls.
                        state     <= WR;
                        mem_req   <= 1'b1;
                        mem_addr  <= {arr_tag, idx};
                        mem_wdata <= arr_data;
                    end else if (last_line) begin
                        state      <= DONE;
                        drain_done <= 1'b1;
                    end else begin
                        state <= RD;
                        idx   <= idx + 1'b1;
                    end
                end

                WR: begin
                    if (mem_ready) begin
                        state         <= CLR;
                        mem_req       <= 1'b0;
                        arr_clr       <= 1'b1;
                        lines_written <= lines_written + 1'b1;
                    end
                end

                CLR: begin
                    arr_clr <= 1'b0;
                    if (last_line) begin
                        state      <= DONE;
                        drain_done <= 1'b1;
                    end else begin
                        state <= RD;
                        idx   <= idx + 1'b1;
                    end
                end

                DONE: begin
                    // lines_written keeps its value until the next drain_req.
                    state      <= IDLE;
                    drain_done <= 1'b0;
                    busy       <= 1'b0;
                end

                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    drain_done <= 1'b0;
                    mem_req    <= 1'b0;
                    arr_clr    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_drain_unit.sv
// tb/tb_cache_drain_unit.sv - randomized self-checking bench for cache_drain_unit
module tb_cache_drain_unit;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // Unit 0: NUM_LINES=4, INVALIDATE=0. Unit 1: NUM_LINES=8, INVALIDATE=1.
    logic         dreq[2];
    logic         mready[2];
    logic         av[2];
    logic         ad[2];
    logic [25:0]  at[2];
    logic [127:0] adat[2];

    logic         a_busy, a_done, a_clr, a_req;
    logic [1:0]   a_idx;
    logic [27:0]  a_addr;
    logic [127:0] a_wdata;
    logic [2:0]   a_lw;
    logic         b_busy, b_done, b_clr, b_req;
    logic [2:0]   b_idx;
    logic [28:0]  b_addr;
    logic [127:0] b_wdata;
    logic [3:0]   b_lw;

    cache_drain_unit #(.NUM_LINES(4), .LINE_BITS(128), .TAG_BITS(26), .INVALIDATE(0)) dut_a (
        .clock(clock), .reset(reset), .drain_req(dreq[0]), .busy(a_busy), .drain_done(a_done),
        .arr_idx(a_idx), .arr_valid(av[0]), .arr_dirty(ad[0]), .arr_tag(at[0]), .arr_data(adat[0]),
        .arr_clr(a_clr), .mem_req(a_req), .mem_addr(a_addr), .mem_wdata(a_wdata),
        .mem_ready(mready[0]), .lines_written(a_lw)
    );

    cache_drain_unit #(.NUM_LINES(8), .LINE_BITS(128), .TAG_BITS(26), .INVALIDATE(1)) dut_b (
        .clock(clock), .reset(reset), .drain_req(dreq[1]), .busy(b_busy), .drain_done(b_done),
        .arr_idx(b_idx), .arr_valid(av[1]), .arr_dirty(ad[1]), .arr_tag(at[1]), .arr_data(adat[1]),
        .arr_clr(b_clr), .mem_req(b_req), .mem_addr(b_addr), .mem_wdata(b_wdata),
        .mem_ready(mready[1]), .lines_written(b_lw)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Cache array contents kept by the bench.
    logic         mv[2][8];
    logic         md[2][8];
    logic [25:0]  mt[2][8];
    logic [127:0] mdat[2][8];

    // Memory-side stall schedule: waits[u][k] idle cycles before write k is accepted.
    int waits[2][16];
    int k[2], wcnt[2];
    bit pending[2];
    logic [28:0]  hold_a[2];
    logic [127:0] hold_d[2];

    // Observations.
    int done_cnt[2], done_cyc[2];
    int visit[2][16], nvisit[2];
    logic [28:0]  wa[2][16];
    logic [127:0] wd[2][16];
    int nwr[2];
    int ci[2][16], nclr[2];
    logic s_busy[2], s_req[2];
    int s_lw[2];

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int wait_of(input int u);
        return (k[u] < 16) ? waits[u][k[u]] : 0;
    endfunction

    // Advance to the next falling edge, then observe the DUTs and drive the
    // array read port and mem_ready for the rest of the cycle.
    task automatic step();
        logic         o_busy, o_done, o_clr, o_req;
        int           o_idx, o_lw;
        logic [28:0]  o_addr;
        logic [127:0] o_wd;
        @(negedge clock);
        cyc++;
        dreq[0] = 1'b0;
        dreq[1] = 1'b0;
        for (int u = 0; u < 2; u++) begin
            if (u == 0) begin
                o_busy = a_busy; o_done = a_done; o_clr = a_clr; o_req = a_req;
                o_idx = int'(a_idx); o_addr = {1'b0, a_addr}; o_wd = a_wdata; o_lw = int'(a_lw);
            end else begin
                o_busy = b_busy; o_done = b_done; o_clr = b_clr; o_req = b_req;
                o_idx = int'(b_idx); o_addr = b_addr; o_wd = b_wdata; o_lw = int'(b_lw);
            end
            s_busy[u] = o_busy;
            s_req[u]  = o_req;
            s_lw[u]   = o_lw;
            if (o_done) begin
                done_cnt[u]++;
                done_cyc[u] = cyc;
            end
            if (o_busy && (nvisit[u] == 0 || visit[u][(nvisit[u] - 1) % 16] != o_idx)) begin
                if (nvisit[u] < 16) visit[u][nvisit[u]] = o_idx;
                nvisit[u]++;
            end
            if (o_clr) begin
                if (nclr[u] < 16) ci[u][nclr[u]] = o_idx;
                nclr[u]++;
                md[u][o_idx] = 1'b0;
                if (u == 1) mv[u][o_idx] = 1'b0;
            end
            if (o_req) begin
                if (pending[u]) begin
                    chk("req_addr_stable", o_addr, hold_a[u]);
                    chk("req_data_stable", o_wd, hold_d[u]);
                end
                if (wcnt[u] >= wait_of(u)) begin
                    mready[u] = 1'b1;
                    if (nwr[u] < 16) begin
                        wa[u][nwr[u]] = o_addr;
                        wd[u][nwr[u]] = o_wd;
                    end
                    nwr[u]++;
                    k[u]++;
                    wcnt[u] = 0;
                    pending[u] = 1'b0;
                end else begin
                    mready[u] = 1'b0;
                    wcnt[u]++;
                    pending[u] = 1'b1;
                    hold_a[u] = o_addr;
                    hold_d[u] = o_wd;
                end
            end else begin
                if (pending[u]) chk("req_held", o_req, 1);
                pending[u] = 1'b0;
                mready[u] = 1'($urandom_range(0, 1));
            end
            av[u]   = mv[u][o_idx];
            ad[u]   = md[u][o_idx];
            at[u]   = mt[u][o_idx];
            adat[u] = mdat[u][o_idx];
        end
    endtask

    task automatic clear_obs(input int u);
        done_cnt[u] = 0; nvisit[u] = 0; nwr[u] = 0; nclr[u] = 0;
        k[u] = 0; wcnt[u] = 0; pending[u] = 1'b0;
    endtask

    task automatic rand_lines(input int u, input int dirty_pct);
        for (int i = 0; i < 8; i++) begin
            mv[u][i]   = 1'($urandom_range(0, 99) < 70);
            md[u][i]   = 1'($urandom_range(0, 99) < dirty_pct);
            mt[u][i]   = 26'($urandom());
            mdat[u][i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        for (int i = 0; i < 16; i++) waits[u][i] = $urandom_range(0, 3);
    endtask

    // Reference: every valid+dirty line in ascending order produces one write
    // of {tag, index}; latency is 2N+1 plus 2+stall cycles per written line.
    task automatic run_drain(input int u, input bit repulse);
        int n, exp_n, exp_lat, start, steps;
        logic [28:0]  ea[16];
        logic [127:0] ed[16];
        int           eidx[16];
        logic         ev[8], edt[8];
        n = (u == 1) ? 8 : 4;
        exp_n = 0;
        exp_lat = 2 * n + 1;
        for (int i = 0; i < 8; i++) begin
            ev[i]  = mv[u][i];
            edt[i] = md[u][i];
        end
        for (int i = 0; i < n; i++) begin
            if (mv[u][i] && md[u][i]) begin
                ea[exp_n]   = (29'(mt[u][i]) * 29'(n)) + 29'(i);
                ed[exp_n]   = mdat[u][i];
                eidx[exp_n] = i;
                exp_lat    += 2 + waits[u][exp_n];
                exp_n++;
                edt[i] = 1'b0;
                if (u == 1) ev[i] = 1'b0;
            end
        end
        clear_obs(u);
        start = cyc;
        dreq[u] = 1'b1;
        step();
        chk("busy_start", s_busy[u], 1);
        steps = 1;
        while (done_cnt[u] == 0 && steps < 400) begin
            if (repulse && (steps == 3 || steps == 6)) dreq[u] = 1'b1;
            step();
            steps++;
        end
        chk("done_seen", done_cnt[u], 1);
        chk("latency", done_cyc[u] - start, exp_lat);
        step(); step(); step();
        chk("done_once", done_cnt[u], 1);
        chk("busy_after", s_busy[u], 0);
        chk("lines_written", s_lw[u], exp_n);
        chk("n_writes", nwr[u], exp_n);
        chk("n_clr", nclr[u], exp_n);
        for (int i = 0; i < exp_n && i < nwr[u] && i < 16; i++) begin
            chk("wr_addr", wa[u][i], ea[i]);
            chk("wr_data", wd[u][i], ed[i]);
        end
        for (int i = 0; i < exp_n && i < nclr[u] && i < 16; i++) chk("clr_idx", ci[u][i], eidx[i]);
        chk("visit_cnt", nvisit[u], n);
        for (int i = 0; i < n && i < nvisit[u]; i++) chk("visit_order", visit[u][i], i);
        for (int i = 0; i < n; i++) begin
            chk("final_valid", mv[u][i], ev[i]);
            chk("final_dirty", md[u][i], edt[i]);
        end
    endtask

    initial begin
        int steps;
        logic [25:0] t7;
        reset = 1'b1;
        for (int u = 0; u < 2; u++) begin
            dreq[u] = 1'b0; mready[u] = 1'b0;
            av[u] = 1'b0; ad[u] = 1'b0; at[u] = '0; adat[u] = '0;
            for (int i = 0; i < 8; i++) begin
                mv[u][i] = 1'b0; md[u][i] = 1'b0; mt[u][i] = '0; mdat[u][i] = '0;
            end
            for (int i = 0; i < 16; i++) waits[u][i] = 0;
            clear_obs(u);
        end
        step(); step();
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_req", a_req, 0);
        chk("rst_clr", a_clr, 0);
        chk("rst_lw", a_lw, 0);
        chk("rst_addr", a_addr, 0);
        chk("rst_wdata", a_wdata, 0);
        chk("rst_idx", a_idx, 0);
        chk("rst_b_req", b_req, 0);
        reset = 1'b0;
        step();
        chk("idle_busy", a_busy, 0);

        // All lines valid but clean: no writes, 9-cycle drain.
        for (int i = 0; i < 4; i++) begin
            mv[0][i] = 1'b1; md[0][i] = 1'b0; mt[0][i] = 26'($urandom());
        end
        run_drain(0, 1'b0);

        // Lines 0 and 2 dirty with tag 0.
        for (int i = 0; i < 4; i++) begin
            mv[0][i] = 1'b1; md[0][i] = 1'b0; mt[0][i] = 26'($urandom()); mdat[0][i] = '0;
        end
        md[0][0] = 1'b1; mt[0][0] = '0; mdat[0][0] = 128'd10 << 32;
        md[0][2] = 1'b1; mt[0][2] = '0; mdat[0][2] = 128'd1234;
        for (int i = 0; i < 16; i++) waits[0][i] = 0;
        run_drain(0, 1'b0);

        // Memory stalls five cycles on one write.
        for (int i = 0; i < 4; i++) begin
            mv[0][i] = 1'b1; md[0][i] = 1'b0;
            mdat[0][i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        md[0][1] = 1'b1;
        waits[0][0] = 5;
        run_drain(0, 1'b0);

        // Extra drain_req pulses during a drain are ignored.
        rand_lines(0, 50);
        run_drain(0, 1'b1);

        for (int r = 0; r < 6; r++) begin
            rand_lines(0, 50);
            run_drain(0, 1'b0);
        end

        // Reset while a write is stalled.
        for (int i = 0; i < 4; i++) begin
            mv[0][i] = 1'b1; md[0][i] = 1'b0;
        end
        md[0][1] = 1'b1;
        waits[0][0] = 1000;
        clear_obs(0);
        dreq[0] = 1'b1;
        steps = 0;
        do begin
            step();
            steps++;
        end while (!s_req[0] && steps < 50);
        chk("rst_reach_wr", s_req[0], 1);
        step(); step();
        chk("rst_req_stalled", s_req[0], 1);
        reset = 1'b1;
        pending[0] = 1'b0;
        step();
        chk("rst_req_low", s_req[0], 0);
        chk("rst_busy_low", s_busy[0], 0);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) step();
        chk("rst_no_done", done_cnt[0], 0);
        chk("rst_no_clr", nclr[0], 0);
        chk("rst_no_write", nwr[0], 0);
        chk("rst_line_dirty", md[0][1], 1);
        waits[0][0] = 0;

        // Eight lines with INVALIDATE: last line dirty, no wrap back to 0.
        rand_lines(1, 0);
        t7 = 26'($urandom());
        mv[1][7] = 1'b1; md[1][7] = 1'b1; mt[1][7] = t7;
        run_drain(1, 1'b0);
        if (nwr[1] >= 1 && nwr[1] <= 16) chk("b_last_addr", wa[1][nwr[1] - 1], {t7, 3'd7});
        else chk("b_last_addr_cnt", nwr[1], 1);
        chk("b_valid7", mv[1][7], 0);
        chk("b_dirty7", md[1][7], 0);

        for (int r = 0; r < 3; r++) begin
            rand_lines(1, 50);
            run_drain(1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_drain_unit.md
CACHE_DRAIN_UNIT -- requirements
Module: cache_drain_unit

Interface
REQ-001 SHALL have parameter NUM_LINES, default 4, number of direct-mapped cache lines (power of two, >=2).
REQ-002 SHALL have parameter LINE_BITS, default 128, cache/memory line width.
REQ-003 SHALL have parameter TAG_BITS, default 26, stored tag width.
REQ-004 SHALL have parameter INVALIDATE, default 0; 1 = clear valid as well as dirty on writeback.
REQ-005 SHALL have derived constant IDX_BITS = $clog2(NUM_LINES) and LADDR_BITS = TAG_BITS+IDX_BITS.
REQ-006 SHALL use one clock; reset is synchronous and active-high. Ports: clock in 1 rising-edge clock; reset in 1 sync active-high reset.
REQ-007 drain_req in 1: one-cycle pulse from MEM stage on opcode 7'h7F.
REQ-008 busy out 1: drain in progress; pipeline stall.
REQ-009 drain_done out 1: one-cycle pulse when drain completes.
REQ-010 arr_idx out IDX_BITS: cache array read/update index.
REQ-011 arr_valid, arr_dirty in 1 each: line state, registered, valid one cycle after arr_idx.
REQ-012 arr_tag in TAG_BITS; arr_data in LINE_BITS: line tag/data, same timing as REQ-011.
REQ-013 arr_clr out 1: clear dirty (and valid if INVALIDATE) of line arr_idx this cycle.
REQ-014 mem_req out 1; mem_addr out LADDR_BITS; mem_wdata out LINE_BITS: line write request.
REQ-015 mem_ready in 1: memory accepts request in the cycle mem_req&&mem_ready.
REQ-016 lines_written out IDX_BITS+1: count of lines written back in the last drain.

Function
REQ-017 FSM states SHALL be IDLE, RD, CHK, WR, CLR, DONE.
REQ-018 IDLE: drain_req -> RD, idx=0, lines_written=0, busy=1 from next cycle.
REQ-019 RD: drive arr_idx=idx; next cycle -> CHK.
REQ-020 CHK: valid&&dirty -> WR, latching tag/data; else idx==NUM_LINES-1 -> DONE, else idx+1 -> RD.
REQ-021 WR: mem_req=1, mem_addr={tag,idx}, mem_wdata=latched data, held stable until mem_ready; mem_ready same cycle as entry accepted; on accept -> CLR, lines_written+1.
REQ-022 CLR: arr_clr=1 one cycle for idx; then last index -> DONE, else idx+1 -> RD.
REQ-023 DONE: drain_done=1 for one cycle, busy=0 afterwards, -> IDLE; lines_written held until next drain_req.
REQ-024 Clean or invalid lines SHALL generate no mem_req and no arr_clr.
REQ-025 drain_req while not IDLE SHALL be ignored (no restart, no queueing).
REQ-026 Index SHALL not wrap: exactly NUM_LINES lines visited per drain, each once, ascending.
REQ-027 Drain latency SHALL be 2*NUM_LINES+1 cycles with zero dirty lines; +2+wait cycles per dirty line.
REQ-028 mem_req SHALL never be asserted outside WR; arr_clr never outside CLR.

Reset
REQ-029 Reset SHALL force IDLE, idx=0, busy=0, drain_done=0, mem_req=0, arr_clr=0, lines_written=0, mem_addr/mem_wdata=0.
REQ-030 Reset mid-drain (incl. WR with mem_req held) SHALL abort: mem_req low next cycle, no further arr_clr, no drain_done.

Structure
REQ-031 State enum, opcode constant DRAIN_OPC=7'h7F and line-width default SHALL live in a shared cache package.
REQ-032 SHALL be one flat module; no sub-module (FSM + counter only).

Verification
REQ-033 NUM_LINES=4, all clean, drain_req -> drain_done 9 cycles later, zero mem_req, lines_written=0.
REQ-034 Line 0 dirty tag 0, word1=10; line 2 dirty tag 0, word0=1234; mem_ready=1 -> writes to addr 0 then 2 only, lines_written=2, dirty bits cleared.
REQ-035 mem_ready low 5 cycles during WR -> mem_req/addr/data stable all 5 cycles, single accept, total latency +5.
REQ-036 drain_req pulsed again mid-drain -> ignored, exactly one drain_done, line visit order 0..3 unchanged.
REQ-037 Reset asserted in WR with mem_ready=0 -> mem_req=0 next cycle, busy=0, no drain_done, no arr_clr.
REQ-038 INVALIDATE=1, NUM_LINES=8, line 7 dirty -> last write addr {tag,3'd7}, valid and dirty both cleared, no wrap to index 0.
